// File: rtl/issue_ctrl_pkg.sv
// rtl/issue_ctrl_pkg.sv - shared widths, default latencies and helpers for the issue controller
package issue_ctrl_pkg;

    localparam int HZ_CNT_WIDTH   = 4;
    localparam int HZ_CNT_MAX     = (1 << HZ_CNT_WIDTH) - 1;

    localparam int DEF_EX_DEPTH   = 3;
    localparam int DEF_MUL_EXTRA  = 1;
    localparam int DEF_LOAD_EXTRA = 2;
    localparam int DEF_BR_LAT     = 2;

    localparam int RS_RA_BIT      = 0;
    localparam int RS_RB_BIT      = 1;
    localparam int RS_RC_BIT      = 2;

    typedef logic [HZ_CNT_WIDTH-1:0] hz_cnt_t;
    typedef logic [4:0]              reg_addr_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/issue_ctrl_if.sv
// rtl/issue_ctrl_if.sv - decode-to-issue handshake bundle
interface issue_ctrl_if;
    import issue_ctrl_pkg::*;

    logic        id_valid_i;
    reg_addr_t   id_addr_ra_i;
    reg_addr_t   id_addr_rb_i;
    reg_addr_t   id_addr_rc_i;
    logic [2:0]  id_rsuse_i;
    reg_addr_t   id_addr_rd_i;
    logic        id_we_i;
    logic        id_usemult_i;
    logic        id_dm_re_i;
    logic        id_sr_we_i;
    logic        id_branchen_i;
    logic        ext_stall_i;

    logic        issue_o;
    logic        stall_o;
    logic        bubble_o;
    logic        busy_o;
    logic [15:0] stall_cnt_o;

    modport master (
        output id_valid_i, id_addr_ra_i, id_addr_rb_i, id_addr_rc_i, id_rsuse_i,
               id_addr_rd_i, id_we_i, id_usemult_i, id_dm_re_i, id_sr_we_i,
               id_branchen_i, ext_stall_i,
        input  issue_o, stall_o, bubble_o, busy_o, stall_cnt_o
    );

    modport slave (
        input  id_valid_i, id_addr_ra_i, id_addr_rb_i, id_addr_rc_i, id_rsuse_i,
               id_addr_rd_i, id_we_i, id_usemult_i, id_dm_re_i, id_sr_we_i,
               id_branchen_i, ext_stall_i,
        output issue_o, stall_o, bubble_o, busy_o, stall_cnt_o
    );

endinterface

// File: rtl/issue_ctrl_hazard_scoreboard.sv
// rtl/issue_ctrl_hazard_scoreboard.sv - per-register write countdowns with busy and rd-count lookups
module hazard_scoreboard
    import issue_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       freeze_i,
    input  logic       load_i,
    input  reg_addr_t  load_addr_i,
    input  hz_cnt_t    load_val_i,
    input  reg_addr_t  src_a_i,
    input  reg_addr_t  src_b_i,
    input  reg_addr_t  src_c_i,
    output logic [2:0] src_busy_o,
    input  reg_addr_t  rd_addr_i,
    output hz_cnt_t    rd_cnt_o,
    output logic       any_busy_o
);

    logic [31:0][HZ_CNT_WIDTH-1:0] cnt_q;
    logic [31:0][HZ_CNT_WIDTH-1:0] cnt_d;

    // A fresh load replaces the countdown of the same entry in the same cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (!freeze_i) begin
            for (int i = 0; i < 32; i++) begin
                if (load_i && (load_addr_i == 5'(i))) begin
                    cnt_d[i] = load_val_i;
                end else if (cnt_q[i] != '0) begin
                    cnt_d[i] = cnt_q[i] - hz_cnt_t'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign src_busy_o[0] = (cnt_q[src_a_i] != '0);
    assign src_busy_o[1] = (cnt_q[src_b_i] != '0);
    assign src_busy_o[2] = (cnt_q[src_c_i] != '0);
    assign rd_cnt_o      = cnt_q[rd_addr_i];
    assign any_busy_o    = (cnt_q != '0);

endmodule

// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - in-order issue interlock for RAW, WAW, status and branch-shadow hazards
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int EX_DEPTH   = DEF_EX_DEPTH,
    parameter int MUL_EXTRA  = DEF_MUL_EXTRA,
    parameter int LOAD_EXTRA = DEF_LOAD_EXTRA,
    parameter int BR_LAT     = DEF_BR_LAT
) (
    input  logic        clk,
    input  logic        rst,
    issue_ctrl_if.slave io
);

    localparam int      MAX_EXTRA = max_int(MUL_EXTRA, LOAD_EXTRA);
    localparam hz_cnt_t LAT_ALU   = hz_cnt_t'(EX_DEPTH);
    localparam hz_cnt_t LAT_MUL   = hz_cnt_t'(EX_DEPTH + MUL_EXTRA);
    localparam hz_cnt_t LAT_LOAD  = hz_cnt_t'(EX_DEPTH + LOAD_EXTRA);
    localparam hz_cnt_t LAT_BOTH  = hz_cnt_t'(EX_DEPTH + MAX_EXTRA);
    localparam hz_cnt_t SHADOW    = hz_cnt_t'(BR_LAT);

    if ((EX_DEPTH + MAX_EXTRA > HZ_CNT_MAX) || (BR_LAT > HZ_CNT_MAX)) begin : g_lat_check
        $error("issue_ctrl: latency does not fit the hazard counter width");
    end

    hz_cnt_t     lat;
    hz_cnt_t     sr_cnt_q, sr_cnt_d;
    hz_cnt_t     shadow_q, shadow_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [2:0]  src_busy;
    hz_cnt_t     rd_cnt;
    logic        sb_busy;
    logic        hazard;
    logic        issue;
    logic        bubble;

    // Combined mult+load takes the longer extra, not the sum.
    always_comb begin
        lat = LAT_ALU;
        case ({io.id_usemult_i, io.id_dm_re_i})
            2'b10:   lat = LAT_MUL;
            2'b01:   lat = LAT_LOAD;
            2'b11:   lat = LAT_BOTH;
            default: lat = LAT_ALU;
        endcase
    end

    hazard_scoreboard u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .freeze_i    (io.ext_stall_i),
        .load_i      (issue & io.id_we_i),
        .load_addr_i (io.id_addr_rd_i),
        .load_val_i  (lat),
        .src_a_i     (io.id_addr_ra_i),
        .src_b_i     (io.id_addr_rb_i),
        .src_c_i     (io.id_addr_rc_i),
        .src_busy_o  (src_busy),
        .rd_addr_i   (io.id_addr_rd_i),
        .rd_cnt_o    (rd_cnt),
        .any_busy_o  (sb_busy)
    );

    always_comb begin
        hazard = (io.id_rsuse_i[RS_RA_BIT] & src_busy[0])
               | (io.id_rsuse_i[RS_RB_BIT] & src_busy[1])
               | (io.id_rsuse_i[RS_RC_BIT] & src_busy[2])
               | (io.id_we_i & (rd_cnt > lat))
               | (io.id_sr_we_i & (sr_cnt_q > lat))
               | (io.id_branchen_i & (sr_cnt_q != '0))
               | (shadow_q != '0);
    end

    assign issue  = io.id_valid_i & ~hazard & ~io.ext_stall_i & ~rst;
    assign bubble = io.id_valid_i &  hazard & ~io.ext_stall_i & ~rst;

    always_comb begin
        sr_cnt_d    = sr_cnt_q;
        shadow_d    = shadow_q;
        stall_cnt_d = stall_cnt_q;
        if (!io.ext_stall_i) begin
            if (issue && io.id_sr_we_i) begin
                sr_cnt_d = lat;
            end else if (sr_cnt_q != '0) begin
                sr_cnt_d = sr_cnt_q - hz_cnt_t'(1);
            end
            if (issue && io.id_branchen_i) begin
                shadow_d = SHADOW;
            end else if (shadow_q != '0) begin
                shadow_d = shadow_q - hz_cnt_t'(1);
            end
            if (bubble && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_cnt_q    <= '0;
            shadow_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            sr_cnt_q    <= sr_cnt_d;
            shadow_q    <= shadow_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign io.issue_o     = issue;
    assign io.bubble_o    = bubble;
    assign io.stall_o     = (io.id_valid_i & hazard) | io.ext_stall_i | rst;
    assign io.busy_o      = sb_busy | (sr_cnt_q != '0) | (shadow_q != '0);
    assign io.stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// tb/tb_issue_ctrl.sv - self-checking bench for issue_ctrl
module tb_issue_ctrl;

    localparam int EX = 3;
    localparam int MX = 1;
    localparam int LX = 2;
    localparam int BR = 2;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    issue_ctrl_if ifc ();

    issue_ctrl #(
        .EX_DEPTH   (EX),
        .MUL_EXTRA  (MX),
        .LOAD_EXTRA (LX),
        .BR_LAT     (BR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (ifc)
    );

    // Reference model: each tracked resource remembers the active-cycle time at which it frees up.
    int m_now;
    int m_wr[32];
    int m_sr;
    int m_br;
    int m_sc;

    function automatic int m_rem(input int done);
        return (done > m_now) ? done - m_now : 0;
    endfunction

    function automatic int m_lat(input bit mul, input bit ld);
        if (mul && ld) return EX + ((MX > LX) ? MX : LX);
        return EX + (mul ? MX : 0) + (ld ? LX : 0);
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 32; i++) m_wr[i] = 0;
        m_sr = 0;
        m_br = 0;
        m_sc = 0;
    endtask

    task automatic drive(input bit v, input int ra, input int rb, input int rc, input logic [2:0] use_m,
                         input int rd, input bit we, input bit mul, input bit ld, input bit srwe,
                         input bit br, input bit ext);
        ifc.id_valid_i    = v;
        ifc.id_addr_ra_i  = 5'(ra);
        ifc.id_addr_rb_i  = 5'(rb);
        ifc.id_addr_rc_i  = 5'(rc);
        ifc.id_rsuse_i    = use_m;
        ifc.id_addr_rd_i  = 5'(rd);
        ifc.id_we_i       = we;
        ifc.id_usemult_i  = mul;
        ifc.id_dm_re_i    = ld;
        ifc.id_sr_we_i    = srwe;
        ifc.id_branchen_i = br;
        ifc.ext_stall_i   = ext;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1, 1, 2, 3, 3'b111, 4, 1, 0, 0, 1, 1, 0);
        #1 rst = 1'b1;
        #1;
        total++; if (ifc.issue_o !== 1'b0) begin bad++; $display("FAIL reset_issue got=%b want=0", ifc.issue_o); end
        total++; if (ifc.stall_o !== 1'b1) begin bad++; $display("FAIL reset_stall got=%b want=1", ifc.stall_o); end
        total++; if (ifc.bubble_o !== 1'b0) begin bad++; $display("FAIL reset_bubble got=%b want=0", ifc.bubble_o); end
        total++; if (ifc.busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", ifc.busy_o); end
        total++; if (ifc.stall_cnt_o !== 16'd0) begin bad++; $display("FAIL reset_stall_cnt got=%0d want=0", ifc.stall_cnt_o); end
        tick();
        rst = 1'b0;
        idle();
    endtask

    task automatic test_raw();
        do_reset();
        drive(1, 0, 0, 0, 3'b000, 3, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        total++; if (ifc.issue_o !== 1'b1) begin bad++; $display("FAIL raw_writer issue got=%b want=1", ifc.issue_o); end
        tick();
        for (int t = 1; t <= 4; t++) begin
            drive(1, 3, 0, 0, 3'b001, 4, 1, 0, 0, 0, 0, 0);
            @(negedge clk);
            total++;
            if (ifc.issue_o !== 1'(t == 4) || ifc.bubble_o !== 1'(t < 4)) begin
                bad++;
                $display("FAIL raw_t%0d issue/bubble got=%b/%b want=%b/%b", t, ifc.issue_o, ifc.bubble_o, t == 4, t < 4);
            end
            tick();
        end
        idle();
        @(negedge clk);
        total++; if (ifc.stall_cnt_o !== 16'd3) begin bad++; $display("FAIL raw_stall_cnt got=%0d want=3", ifc.stall_cnt_o); end
        tick();
    endtask

    task automatic test_waw();
        do_reset();
        drive(1, 0, 0, 0, 3'b000, 5, 1, 0, 1, 0, 0, 0);
        tick();
        for (int t = 1; t <= 3; t++) begin
            drive(1, 0, 0, 0, 3'b000, 5, 1, 0, 0, 0, 0, 0);
            @(negedge clk);
            total++;
            if (ifc.issue_o !== 1'(t == 3) || ifc.stall_o !== 1'(t < 3)) begin
                bad++;
                $display("FAIL waw_t%0d issue/stall got=%b/%b want=%b/%b", t, ifc.issue_o, ifc.stall_o, t == 3, t < 3);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_branch();
        do_reset();
        drive(1, 0, 0, 0, 3'b000, 1, 1, 0, 0, 1, 0, 0);
        tick();
        for (int t = 1; t <= 7; t++) begin
            if (t <= 4) drive(1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 1, 0);
            else        drive(1, 0, 0, 0, 3'b000, 2, 1, 0, 0, 0, 0, 0);
            @(negedge clk);
            total++;
            if (ifc.issue_o !== 1'(t == 4 || t == 7) || ifc.bubble_o !== 1'(t != 4 && t != 7)) begin
                bad++;
                $display("FAIL branch_t%0d issue/bubble got=%b/%b want=%b/%b", t, ifc.issue_o, ifc.bubble_o,
                         t == 4 || t == 7, t != 4 && t != 7);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_ext_stall();
        logic [10:0] ext_pat    = 11'b000_0110_1100;
        logic [10:0] issue_pat  = 11'b100_0001_0011;
        logic [10:0] bubble_pat = 11'b011_1000_0000;
        logic [10:0] stall_pat  = 11'b011_1110_1100;
        do_reset();
        for (int t = 0; t <= 10; t++) begin
            if (t < 5) drive(1, 0, 0, 0, 3'b000, (t < 2) ? 10 + t : 12, 1, 0, 0, 0, 0, ext_pat[t]);
            else       drive(1, 12, 0, 0, 3'b001, 20, 1, 0, 0, 0, 0, ext_pat[t]);
            @(negedge clk);
            total++;
            if (ifc.issue_o !== issue_pat[t] || ifc.bubble_o !== bubble_pat[t] || ifc.stall_o !== stall_pat[t]) begin
                bad++;
                $display("FAIL ext_t%0d issue/bubble/stall got=%b/%b/%b want=%b/%b/%b", t, ifc.issue_o, ifc.bubble_o,
                         ifc.stall_o, issue_pat[t], bubble_pat[t], stall_pat[t]);
            end
            tick();
        end
        idle();
        @(negedge clk);
        total++; if (ifc.stall_cnt_o !== 16'd3) begin bad++; $display("FAIL ext_stall_cnt got=%0d want=3", ifc.stall_cnt_o); end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1, 0, 0, 0, 3'b000, 7, 1, 1, 0, 0, 0, 0);
        tick();
        drive(1, 7, 0, 0, 3'b001, 8, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        total++; if (ifc.bubble_o !== 1'b1) begin bad++; $display("FAIL rstmid_bubble got=%b want=1", ifc.bubble_o); end
        tick();
        total++; if (ifc.busy_o !== 1'b1 || ifc.stall_cnt_o !== 16'd1) begin
            bad++; $display("FAIL rstmid_pre busy/cnt got=%b/%0d want=1/1", ifc.busy_o, ifc.stall_cnt_o);
        end
        rst = 1'b1;
        #1;
        total++; if (ifc.busy_o !== 1'b0 || ifc.stall_cnt_o !== 16'd0) begin
            bad++; $display("FAIL rstmid_clear busy/cnt got=%b/%0d want=0/0", ifc.busy_o, ifc.stall_cnt_o);
        end
        total++; if (ifc.issue_o !== 1'b0 || ifc.stall_o !== 1'b1 || ifc.bubble_o !== 1'b0) begin
            bad++; $display("FAIL rstmid_out issue/stall/bubble got=%b/%b/%b want=0/1/0", ifc.issue_o, ifc.stall_o, ifc.bubble_o);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++; if (ifc.issue_o !== 1'b1) begin bad++; $display("FAIL rstmid_consumer issue got=%b want=1", ifc.issue_o); end
        tick();
        idle();
    endtask

    task automatic test_random();
        do_reset();
        m_clear();
        m_now = 0;
        for (int n = 0; n < 1500; n++) begin
            int ra = $urandom_range(7);
            int rb = $urandom_range(7);
            int rc = $urandom_range(7);
            int rd = $urandom_range(7);
            logic [2:0] um = 3'($urandom_range(7));
            bit v    = ($urandom_range(9) < 8);
            bit we   = ($urandom_range(9) < 7);
            bit mul  = ($urandom_range(3) == 0);
            bit ld   = ($urandom_range(3) == 0);
            bit srwe = ($urandom_range(3) == 0);
            bit br   = ($urandom_range(9) == 0);
            bit ext  = ($urandom_range(11) == 0);
            int  l;
            bit  hz, e_issue, e_stall, e_bubble, e_busy;
            drive(v, ra, rb, rc, um, rd, we, mul, ld, srwe, br, ext);
            if ($urandom_range(99) == 0) begin
                rst = 1'b1;
                #1;
                total++;
                if (ifc.issue_o !== 1'b0 || ifc.stall_o !== 1'b1 || ifc.busy_o !== 1'b0 || ifc.stall_cnt_o !== 16'd0) begin
                    bad++;
                    $display("FAIL rand_reset n=%0d issue/stall/busy/cnt got=%b/%b/%b/%0d want=0/1/0/0", n,
                             ifc.issue_o, ifc.stall_o, ifc.busy_o, ifc.stall_cnt_o);
                end
                m_clear();
                @(posedge clk);
                #1 rst = 1'b0;
                continue;
            end
            l  = m_lat(mul, ld);
            hz = (um[0] && m_rem(m_wr[ra]) > 0) || (um[1] && m_rem(m_wr[rb]) > 0) || (um[2] && m_rem(m_wr[rc]) > 0)
               || (we && m_rem(m_wr[rd]) > l) || (srwe && m_rem(m_sr) > l) || (br && m_rem(m_sr) > 0)
               || (m_rem(m_br) > 0);
            e_issue  = v && !hz && !ext;
            e_bubble = v && hz && !ext;
            e_stall  = (v && hz) || ext;
            e_busy   = (m_rem(m_sr) > 0) || (m_rem(m_br) > 0);
            for (int i = 0; i < 32; i++) if (m_rem(m_wr[i]) > 0) e_busy = 1'b1;
            @(negedge clk);
            total++;
            if (ifc.issue_o !== e_issue || ifc.bubble_o !== e_bubble || ifc.stall_o !== e_stall) begin
                bad++;
                $display("FAIL rand_out n=%0d issue/bubble/stall got=%b/%b/%b want=%b/%b/%b", n, ifc.issue_o,
                         ifc.bubble_o, ifc.stall_o, e_issue, e_bubble, e_stall);
            end
            total++;
            if (ifc.busy_o !== e_busy) begin bad++; $display("FAIL rand_busy n=%0d got=%b want=%b", n, ifc.busy_o, e_busy); end
            total++;
            if (ifc.stall_cnt_o !== 16'(m_sc)) begin
                bad++; $display("FAIL rand_stall_cnt n=%0d got=%0d want=%0d", n, ifc.stall_cnt_o, m_sc);
            end
            @(posedge clk);
            if (!ext) begin
                if (e_bubble && m_sc < 65535) m_sc++;
                if (e_issue) begin
                    if (we)   m_wr[rd] = m_now + 1 + l;
                    if (srwe) m_sr     = m_now + 1 + l;
                    if (br)   m_br     = m_now + 1 + BR;
                end
                m_now++;
            end
            #1;
        end
        idle();
    endtask

    task automatic test_saturate();
        do_reset();
        // Self-dependent mult+load: one issue then five bubbles, repeating.
        drive(1, 1, 0, 0, 3'b001, 1, 1, 1, 1, 0, 0, 0);
        repeat (6000) @(posedge clk);
        @(negedge clk);
        total++; if (ifc.stall_cnt_o !== 16'd5000) begin bad++; $display("FAIL sat_mid got=%0d want=5000", ifc.stall_cnt_o); end
        repeat (73200) @(posedge clk);
        @(negedge clk);
        total++; if (ifc.stall_cnt_o !== 16'hFFFF) begin bad++; $display("FAIL sat_final got=%0h want=ffff", ifc.stall_cnt_o); end
        #1 idle();
    endtask

    initial begin
        test_reset();
        test_raw();
        test_waw();
        test_branch();
        test_ext_stall();
        test_reset_mid();
        test_random();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
